// File: rtl/gen_capture_pkg.sv
// Shared types and helpers for the generator burst-capture controller.
package gen_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN,
    DONE
  } cap_state_e;

  localparam int unsigned BUF_DEPTH = 2;

  // Successor of prev in a counter that wraps to 0 after wrap, modulo 2**width.
  function automatic logic [31:0] next_expected(input logic [31:0] prev,
                                                input logic [31:0] wrap,
                                                input int unsigned width = 32);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (prev == wrap) ? '0 : ((prev + 32'd1) & mask);
  endfunction

endpackage

// File: rtl/sym_fifo2.sv
// Two-entry valid/ready FIFO; the head register drives the read port directly.
module sym_fifo2
  import gen_capture_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  assign rd_data_o  = head_q;
  assign rd_valid_o = (cnt_q != '0);
  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CNT_W'(BUF_DEPTH));
  assign pop        = rd_valid_o && rd_ready_i;
  // A write into a full buffer still lands when the head leaves on the same edge.
  assign push       = wr_en_i && (!full_o || pop);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      head_d = '0;
      cnt_d  = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == '0) head_d = wr_data_i;
          else             tail_d = wr_data_i;
          cnt_d = cnt_q + CNT_W'(1);
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - CNT_W'(1);
        end
        2'b11: begin
          if (cnt_q == CNT_W'(1)) begin
            head_d = wr_data_i;
          end else begin
            head_d = tail_q;
            tail_d = wr_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/gen_capture_ctrl.sv
// Burst capture controller: aligns to generator symbols, qualifies them after a
// stability window, checks the counter sequence and forwards them downstream.
module gen_capture_ctrl
  import gen_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned HOLD_WIDTH  = 4,
  parameter int unsigned BURST_WIDTH = 8,
  parameter int unsigned ERR_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_Start,
  input  logic                   i_Abort,
  input  logic [BURST_WIDTH-1:0] i_Burst_Len,
  input  logic [HOLD_WIDTH-1:0]  i_Hold_Cycles,
  input  logic [DATA_WIDTH-1:0]  i_Wrap_Value,
  input  logic [DATA_WIDTH-1:0]  i_Gen_Data,
  output logic [DATA_WIDTH-1:0]  o_Data,
  output logic                   o_Valid,
  input  logic                   i_Ready,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic                   o_Seq_Err,
  output logic [ERR_WIDTH-1:0]   o_Err_Count,
  output logic                   o_Overflow
);

  cap_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]  d_q;
  logic [DATA_WIDTH-1:0]  prev_q, prev_d;
  logic [DATA_WIDTH-1:0]  wrap_q, wrap_d;
  logic [HOLD_WIDTH-1:0]  hold_q, hold_d;
  logic [HOLD_WIDTH-1:0]  stab_q, stab_d;
  logic [BURST_WIDTH-1:0] len_q, len_d;
  logic [BURST_WIDTH-1:0] sym_cnt_q, sym_cnt_d;
  logic [ERR_WIDTH-1:0]   err_cnt_q, err_cnt_d;
  logic                   qual_q, qual_d;
  logic                   first_q, first_d;
  logic                   seq_err_q, seq_err_d;
  logic                   ovf_q, ovf_d;
  logic                   changed, qualify, mismatch;
  logic                   buf_wr, buf_flush, buf_full, buf_empty, buf_pop;

  assign changed  = (i_Gen_Data != d_q);
  assign qualify  = (state_q == RUN) && !changed && (stab_q == hold_q) && !qual_q;
  assign mismatch = !first_q &&
                    (next_expected(32'(prev_q), 32'(wrap_q), DATA_WIDTH) != 32'(d_q));
  assign buf_pop  = o_Valid && i_Ready;

  assign o_Busy      = (state_q != IDLE);
  assign o_Done      = (state_q == DONE) && !i_Abort;
  assign o_Seq_Err   = seq_err_q;
  assign o_Err_Count = err_cnt_q;
  assign o_Overflow  = ovf_q;

  always_comb begin
    stab_d = stab_q;
    qual_d = qual_q;
    if (changed) begin
      stab_d = '0;
      qual_d = 1'b0;
    end else begin
      if (stab_q < hold_q) stab_d = stab_q + HOLD_WIDTH'(1);
      if (qualify)         qual_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    wrap_d    = wrap_q;
    hold_d    = hold_q;
    len_d     = len_q;
    sym_cnt_d = sym_cnt_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    seq_err_d = seq_err_q;
    ovf_d     = ovf_q;
    buf_wr    = 1'b0;
    buf_flush = 1'b0;
    if (i_Abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      buf_flush = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_Start) begin
            hold_d    = i_Hold_Cycles;
            len_d     = i_Burst_Len;
            wrap_d    = i_Wrap_Value;
            sym_cnt_d = '0;
            err_cnt_d = '0;
            seq_err_d = 1'b0;
            ovf_d     = 1'b0;
            first_d   = 1'b1;
            state_d   = (i_Burst_Len == '0) ? DONE : ARM;
          end
        end
        ARM: begin
          if (changed) state_d = RUN;
        end
        RUN: begin
          if (qualify) begin
            // prev tracks the received value whether it matched or not (resync).
            if (mismatch) begin
              seq_err_d = 1'b1;
              if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
            end
            prev_d  = d_q;
            first_d = 1'b0;
            buf_wr  = 1'b1;
            if (buf_full && !buf_pop) ovf_d = 1'b1;
            sym_cnt_d = sym_cnt_q + BURST_WIDTH'(1);
            if (sym_cnt_d == len_q) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (buf_empty) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      d_q       <= '0;
      prev_q    <= '0;
      wrap_q    <= '0;
      hold_q    <= '0;
      stab_q    <= '0;
      len_q     <= '0;
      sym_cnt_q <= '0;
      err_cnt_q <= '0;
      qual_q    <= 1'b0;
      first_q   <= 1'b0;
      seq_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_q       <= i_Gen_Data;
      prev_q    <= prev_d;
      wrap_q    <= wrap_d;
      hold_q    <= hold_d;
      stab_q    <= stab_d;
      len_q     <= len_d;
      sym_cnt_q <= sym_cnt_d;
      err_cnt_q <= err_cnt_d;
      qual_q    <= qual_d;
      first_q   <= first_d;
      seq_err_q <= seq_err_d;
      ovf_q     <= ovf_d;
    end
  end

  sym_fifo2 #(
    .WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (buf_flush),
    .wr_en_i    (buf_wr),
    .wr_data_i  (d_q),
    .rd_ready_i (i_Ready),
    .rd_data_o  (o_Data),
    .rd_valid_o (o_Valid),
    .full_o     (buf_full),
    .empty_o    (buf_empty)
  );

endmodule
